regfile_mp: RTL

Parametrised multi-port integer register file, the successor to the single-write, 2-read register file in the CPU core.
- Configurable width, depth and number of read/write ports, for a dual-issue pipeline.
- Architectural register 0 is hardwired to zero.
- After reset, a sequential clear sweep zeroes all entries; `init_done` reports when the sweep has finished.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wr_arb.sv | 26 ++
 rtl/regfile_mp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_e;

  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Combinational priority match of the write ports against one address;
// the highest-numbered enabled matching port wins.
module regfile_wr_arb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NWRITE = 2
) (
  input  logic [AW-1:0]                  match_addr,
  input  logic [NWRITE-1:0]              wr_en,
  input  logic [NWRITE-1:0][AW-1:0]      wr_addr,
  input  logic [NWRITE-1:0][XLEN-1:0]    wr_data,
  output logic                           hit,
  output logic [XLEN-1:0]                data
);

  // Ascending scan so later (higher) ports overwrite earlier selections.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NWRITE; j++) begin
      hit  = hit | (wr_en[j] && (wr_addr[j] == match_addr));
      data = (wr_en[j] && (wr_addr[j] == match_addr)) ? wr_data[j] : data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a post-reset clear sweep.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREAD-1:0][AW-1:0]     rd_addr,
  output logic [NREAD-1:0][XLEN-1:0]   rd_data,
  input  logic [NWRITE-1:0]            wr_en,
  input  logic [NWRITE-1:0][AW-1:0]    wr_addr,
  input  logic [NWRITE-1:0][XLEN-1:0]  wr_data,
  output logic                         init_done
);

  rf_state_e         state, next_state;
  logic [AW-1:0]     cnt, next_cnt;
  logic              next_done;
  logic [XLEN-1:0]   mem [NREGS];

  logic              ent_hit  [1:NREGS-1];
  logic [XLEN-1:0]   ent_data [1:NREGS-1];

  for (genvar e = 1; e < NREGS; e++) begin : g_ent
    regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE)) u_arb (
      .match_addr (AW'(e)),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .hit        (ent_hit[e]),
      .data       (ent_data[e])
    );
  end

  // State, sweep counter and init_done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      init_done <= next_done;
    end
  end

  // init_done rises together with the move to READY, one cycle after the last clear.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_done  = init_done;
    case (state)
      INIT: begin
        next_cnt = cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) begin
          next_state = READY;
          next_done  = 1'b1;
        end else begin
          next_state = INIT;
          next_done  = 1'b0;
        end
      end
      READY: begin
        next_state = READY;
        next_done  = 1'b1;
      end
      default: begin
        next_state = INIT;
        next_cnt   = '0;
        next_done  = 1'b0;
      end
    endcase
  end

  // Storage: sweep clears during INIT; port writes only in READY, never to entry 0.
  always_ff @(posedge clk) begin
    if (!rst && (state == INIT) && (cnt == '0)) begin
      mem[0] <= '0;
    end
    for (int e = 1; e < NREGS; e++) begin
      if (!rst && (state == INIT) && (cnt == AW'(e))) begin
        mem[e] <= '0;
      end else if (!rst && (state == READY) && ent_hit[e]) begin
        mem[e] <= ent_data[e];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic            byp_hit  [NREAD];
  logic [XLEN-1:0] byp_data [NREAD];

  for (genvar i = 0; i < NREAD; i++) begin : g_byp
    regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWRITE(NWRITE)) u_byp (
      .match_addr (rd_addr[i]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .hit        (byp_hit[i]),
      .data       (byp_data[i])
    );
  end
`endif

  // Read ports: zero during INIT and for address 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      if ((state == READY) && (rd_addr[i] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        rd_data[i] = byp_hit[i] ? byp_data[i] : mem[rd_addr[i]];
`else
        rd_data[i] = mem[rd_addr[i]];
`endif
      end else begin
        rd_data[i] = '0;
      end
    end
  end

endmodule
